// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller, ALU controller and datapath muxes.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEM_ADDR = 4'd2,
        MEM_RD   = 4'd3,
        MEM_WB   = 4'd4,
        MEM_WR   = 4'd5,
        EXEC     = 4'd6,
        ALU_WB   = 4'd7,
        BRANCH   = 4'd8,
        JUMP     = 4'd9,
        ADDI_EX  = 4'd10,
        ADDI_WB  = 4'd11,
        FAULT    = 4'd15
    } ctrlStateT;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_RT      = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_SEXT    = 2'b10;
    localparam logic [1:0] SRCB_SEXT_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // States that stall on the memory-ready handshake.
    function automatic logic isMemWaitState(input ctrlStateT s);
        return (s == FETCH) || (s == MEM_RD) || (s == MEM_WR);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Memory wait counter with timeout compare; MEM_TIMEOUT = 0 disables the timeout.
module mem_wait_timer #(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic Clk,
    input  logic Reset,
    input  logic waitState,
    input  logic MemReady,
    input  logic stateChange,
    output logic timeout
);

    // countQ holds completed wait cycles; the limit is hit when this cycle's wait would reach it.
    localparam logic [3:0] LastWait = (MEM_TIMEOUT == 0) ? 4'd0 : 4'(MEM_TIMEOUT - 1);

    logic [3:0] countQ;
    logic [3:0] countD;

    always_comb begin
        countD = countQ;
        if (stateChange) begin
            countD = 4'd0;
        end else if (waitState && !MemReady) begin
            countD = countQ + 4'd1;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            countQ <= 4'd0;
        end else begin
            countQ <= countD;
        end
    end

    assign timeout = (MEM_TIMEOUT != 0) && waitState && !MemReady && (countQ == LastWait);

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS sequencing FSM with memory handshake and sticky FAULT trap.
// Optional MULTICYCLE_CTRL_PERF_EN adds RetireCount/CycleCount performance counters.
module multicycle_controller
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [5:0]  Opcode,
    input  logic        Zero,
    input  logic        MemReady,
    output logic        PCEn,
    output logic        IorD,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic        RegDst,
    output logic        MemToReg,
    output logic        RegWrite,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ALUOp,
    output logic [1:0]  PCSource,
    output logic [3:0]  State,
    output logic        Fault
`ifdef MULTICYCLE_CTRL_PERF_EN
    ,
    output logic [31:0] RetireCount,
    output logic [31:0] CycleCount
`endif
);

    ctrlStateT stateQ, stateD;
    logic      isStoreQ, isStoreD;
    logic      timeout;

    mem_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) uWaitTimer (
        .Clk        (Clk),
        .Reset      (Reset),
        .waitState  (isMemWaitState(stateQ)),
        .MemReady   (MemReady),
        .stateChange(stateD != stateQ),
        .timeout    (timeout)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            stateQ   <= FETCH;
            isStoreQ <= 1'b0;
        end else begin
            stateQ   <= stateD;
            isStoreQ <= isStoreD;
        end
    end

    always_comb begin
        stateD   = stateQ;
        isStoreD = isStoreQ;
        case (stateQ)
            FETCH: begin
                if (MemReady)     stateD = DECODE;
                else if (timeout) stateD = FAULT;
            end
            DECODE: begin
                // MEM_ADDR must not look at Opcode, so remember lw/sw here.
                isStoreD = (Opcode == OP_SW);
                case (Opcode)
                    OP_RTYPE:       stateD = EXEC;
                    OP_LW, OP_SW:   stateD = MEM_ADDR;
                    OP_BEQ, OP_BNE: stateD = BRANCH;
                    OP_ADDI:        stateD = ADDI_EX;
                    OP_J:           stateD = JUMP;
                    default:        stateD = FAULT;
                endcase
            end
            MEM_ADDR: stateD = isStoreQ ? MEM_WR : MEM_RD;
            MEM_RD: begin
                if (MemReady)     stateD = MEM_WB;
                else if (timeout) stateD = FAULT;
            end
            MEM_WR: begin
                if (MemReady)     stateD = FETCH;
                else if (timeout) stateD = FAULT;
            end
            MEM_WB:  stateD = FETCH;
            EXEC:    stateD = ALU_WB;
            ALU_WB:  stateD = FETCH;
            ADDI_EX: stateD = ADDI_WB;
            ADDI_WB: stateD = FETCH;
            BRANCH:  stateD = FETCH;
            JUMP:    stateD = FETCH;
            FAULT:   stateD = FAULT;
            default: stateD = FAULT;
        endcase
    end

    always_comb begin
        PCEn     = 1'b0;
        IorD     = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        IRWrite  = 1'b0;
        RegDst   = 1'b0;
        MemToReg = 1'b0;
        RegWrite = 1'b0;
        ALUSrcA  = 1'b0;
        ALUSrcB  = SRCB_RT;
        ALUOp    = ALUOP_ADD;
        PCSource = PCSRC_ALU;
        case (stateQ)
            FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = SRCB_FOUR;
                IRWrite = MemReady;
                PCEn    = MemReady;
            end
            DECODE: ALUSrcB = SRCB_SEXT_SH;
            MEM_ADDR, ADDI_EX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_SEXT;
            end
            MEM_RD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            MEM_WR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            MEM_WB: begin
                RegWrite = 1'b1;
                MemToReg = 1'b1;
            end
            EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = ALUOP_FUNCT;
            end
            ALU_WB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
            end
            ADDI_WB: RegWrite = 1'b1;
            BRANCH: begin
                ALUSrcA  = 1'b1;
                ALUOp    = ALUOP_SUB;
                PCSource = PCSRC_ALUOUT;
                PCEn     = (Opcode == OP_BNE) ? ~Zero : Zero;
            end
            JUMP: begin
                PCSource = PCSRC_JUMP;
                PCEn     = 1'b1;
            end
            default: ;
        endcase
        // State is already FETCH during reset; only the side-effecting enables need masking.
        if (Reset) begin
            PCEn     = 1'b0;
            IRWrite  = 1'b0;
            RegWrite = 1'b0;
            MemWrite = 1'b0;
        end
    end

    assign State = stateQ;
    assign Fault = (stateQ == FAULT);

`ifdef MULTICYCLE_CTRL_PERF_EN
    logic [31:0] retireQ, cycleQ;
    logic        retires;

    assign retires = (stateD == FETCH) &&
                     (stateQ inside {MEM_WB, MEM_WR, ALU_WB, ADDI_WB, BRANCH, JUMP});

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            retireQ <= 32'd0;
            cycleQ  <= 32'd0;
        end else begin
            if (retires)         retireQ <= retireQ + 32'd1;
            if (stateQ != FAULT) cycleQ  <= cycleQ + 32'd1;
        end
    end

    assign RetireCount = retireQ;
    assign CycleCount  = cycleQ;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: latency table, corner sequences, random stream.
module tb_multicycle_controller;

    localparam logic [5:0] OpR    = 6'b000000;
    localparam logic [5:0] OpLw   = 6'b100011;
    localparam logic [5:0] OpSw   = 6'b101011;
    localparam logic [5:0] OpBeq  = 6'b000100;
    localparam logic [5:0] OpBne  = 6'b000101;
    localparam logic [5:0] OpAddi = 6'b001000;
    localparam logic [5:0] OpJ    = 6'b000010;

    typedef struct packed {
        logic [3:0] state;
        logic       pcEn, iorD, memRead, memWrite, irWrite, regDst, memToReg, regWrite, aluSrcA;
        logic [1:0] aluSrcB, aluOp, pcSource;
        logic       fault;
    } outT;

    typedef struct {
        logic [5:0] op;
        logic       zero;
        int         lat;
        int         regW, pcEn, memW, memR;
        string      name;
    } vecT;

    logic Clk, Reset, Zero, MemReady;
    logic [5:0] Opcode;
    logic PCEn, IorD, MemRead, MemWrite, IRWrite, RegDst, MemToReg, RegWrite, ALUSrcA, Fault;
    logic [1:0] ALUSrcB, ALUOp, PCSource;
    logic [3:0] State;
`ifdef MULTICYCLE_CTRL_PERF_EN
    logic [31:0] RetireCount, CycleCount;
`endif

    int compared = 0;
    int mismatched = 0;
    int retired = 0;
    int cycles = 0;
    outT actual;

    multicycle_controller #(.MEM_TIMEOUT(15)) dut (
        .Clk(Clk), .Reset(Reset), .Opcode(Opcode), .Zero(Zero), .MemReady(MemReady),
        .PCEn(PCEn), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .RegDst(RegDst), .MemToReg(MemToReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource), .State(State), .Fault(Fault)
`ifdef MULTICYCLE_CTRL_PERF_EN
        , .RetireCount(RetireCount), .CycleCount(CycleCount)
`endif
    );

    assign actual = {State, PCEn, IorD, MemRead, MemWrite, IRWrite, RegDst, MemToReg, RegWrite,
                     ALUSrcA, ALUSrcB, ALUOp, PCSource, Fault};

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Output table per state code.
    function automatic outT expOut(input logic [3:0] st, input logic mr, input logic zr,
                                   input logic [5:0] op);
        outT o;
        o = '0;
        o.state = st;
        case (st)
            4'd0:  begin o.memRead = 1; o.aluSrcB = 2'b01; o.pcEn = mr; o.irWrite = mr; end
            4'd1:  o.aluSrcB = 2'b11;
            4'd2:  begin o.aluSrcA = 1; o.aluSrcB = 2'b10; end
            4'd3:  begin o.memRead = 1; o.iorD = 1; end
            4'd4:  begin o.regWrite = 1; o.memToReg = 1; end
            4'd5:  begin o.memWrite = 1; o.iorD = 1; end
            4'd6:  begin o.aluSrcA = 1; o.aluOp = 2'b10; end
            4'd7:  begin o.regWrite = 1; o.regDst = 1; end
            4'd8:  begin
                o.aluSrcA = 1; o.aluOp = 2'b01; o.pcSource = 2'b01;
                o.pcEn = (op == OpBne) ? ~zr : zr;
            end
            4'd9:  begin o.pcSource = 2'b10; o.pcEn = 1; end
            4'd10: begin o.aluSrcA = 1; o.aluSrcB = 2'b10; end
            4'd11: o.regWrite = 1;
            4'd15: o.fault = 1;
            default: ;
        endcase
        return o;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, got, want, $time);
        end
    endtask

    // Called at posedge+1; drives inputs, samples at posedge+2, then advances one cycle.
    task automatic checkCycle(input logic [3:0] st, input logic mr, input logic zr,
                              input string name);
        MemReady = mr;
        Zero     = zr;
        #1;
        check(name, 32'(actual), 32'(expOut(st, mr, zr, Opcode)));
        if (st != 4'd15) cycles++;
        @(posedge Clk);
        #1;
    endtask

    task automatic doReset();
        Reset    = 1'b1;
        MemReady = 1'b1;
        Zero     = 1'b1;
        #1;
        check("reset_outputs", 32'(actual), 32'(expOut(4'd0, 1'b0, 1'b0, 6'd0)));
`ifdef MULTICYCLE_CTRL_PERF_EN
        check("reset_counters", {RetireCount[15:0], CycleCount[15:0]}, 32'd0);
`endif
        @(posedge Clk);
        #1;
        Reset   = 1'b0;
        retired = 0;
        cycles  = 0;
    endtask

    // One instruction expressed as its spec phase list; wF/wM are wait cycles before MemReady.
    task automatic runInstr(input logic [5:0] op, input logic zr, input int wF, input int wM,
                            input int nFault);
        logic [3:0] seq[$];
        logic [3:0] st;
        logic       legal;
        int         n;
        legal = 1'b1;
        seq.push_back(4'd0);
        seq.push_back(4'd1);
        case (op)
            OpR:          begin seq.push_back(4'd6); seq.push_back(4'd7); end
            OpLw:         begin seq.push_back(4'd2); seq.push_back(4'd3); seq.push_back(4'd4); end
            OpSw:         begin seq.push_back(4'd2); seq.push_back(4'd5); end
            OpBeq, OpBne: seq.push_back(4'd8);
            OpAddi:       begin seq.push_back(4'd10); seq.push_back(4'd11); end
            OpJ:          seq.push_back(4'd9);
            default:      begin seq.push_back(4'd15); legal = 1'b0; end
        endcase
        foreach (seq[i]) begin
            st = seq[i];
            Opcode = (st == 4'd0) ? 6'($urandom) : op;
            if (st == 4'd15) begin
                for (int k = 0; k < nFault; k++)
                    checkCycle(st, 1'($urandom), 1'($urandom), "fault_hold");
            end else begin
                n = (st == 4'd0) ? wF : ((st == 4'd3 || st == 4'd5) ? wM : 0);
                for (int k = 0; k <= n; k++) begin
                    if (st == 4'd0 || st == 4'd3 || st == 4'd5)
                        checkCycle(st, (k == n), 1'($urandom), "seq");
                    else
                        checkCycle(st, 1'($urandom), (st == 4'd8) ? zr : 1'($urandom), "seq");
                end
            end
        end
        if (legal) retired++;
    endtask

    vecT vecs[9];
    logic [5:0] legalOps[7];
    logic [5:0] badOps[4];

    initial begin
        int lat, rw, pe, mw, mrd;
        bit done;
        logic [5:0] op;

        vecs[0] = '{OpR,    1'b0, 4, 1, 1, 0, 1, "rtype"};
        vecs[1] = '{OpLw,   1'b0, 5, 1, 1, 0, 2, "lw"};
        vecs[2] = '{OpSw,   1'b0, 4, 0, 1, 1, 1, "sw"};
        vecs[3] = '{OpAddi, 1'b0, 4, 1, 1, 0, 1, "addi"};
        vecs[4] = '{OpBeq,  1'b1, 3, 0, 2, 0, 1, "beq_taken"};
        vecs[5] = '{OpBeq,  1'b0, 3, 0, 1, 0, 1, "beq_not"};
        vecs[6] = '{OpBne,  1'b1, 3, 0, 1, 0, 1, "bne_not"};
        vecs[7] = '{OpBne,  1'b0, 3, 0, 2, 0, 1, "bne_taken"};
        vecs[8] = '{OpJ,    1'b0, 3, 0, 2, 0, 1, "jump"};
        legalOps = '{OpR, OpLw, OpSw, OpBeq, OpBne, OpAddi, OpJ};
        badOps   = '{6'b111111, 6'b000001, 6'b100000, 6'b001111};

        Reset = 1'b1; Opcode = 6'd0; Zero = 1'b0; MemReady = 1'b0;
        @(posedge Clk);
        #1;
        doReset();

        // Latency and enable counts with MemReady tied high.
        foreach (vecs[v]) begin
            Opcode = vecs[v].op; Zero = vecs[v].zero; MemReady = 1'b1;
            lat = 0; rw = 0; pe = 0; mw = 0; mrd = 0; done = 0;
            for (int c = 1; c <= 20 && !done; c++) begin
                #1;
                rw += int'(RegWrite); pe += int'(PCEn); mw += int'(MemWrite); mrd += int'(MemRead);
                @(posedge Clk);
                #1;
                lat = c;
                if (State == 4'd0 || State == 4'd15) done = 1;
            end
            check({vecs[v].name, "_latency"}, done ? 32'(lat) : 32'hFFFF_FFFF, 32'(vecs[v].lat));
            check({vecs[v].name, "_enables"}, (rw << 24) | (pe << 16) | (mw << 8) | mrd,
                  (vecs[v].regW << 24) | (vecs[v].pcEn << 16) | (vecs[v].memW << 8) |
                  vecs[v].memR);
        end

        // lw with three stalled cycles in MEM_RD.
        runInstr(OpLw, 1'b0, 0, 3, 0);

        // Illegal opcode: sticky fault for 20 cycles, then reset clears it.
        runInstr(6'b111111, 1'b0, 0, 0, 20);
        doReset();
        check("post_fault_state", {27'd0, Fault, State}, 32'd0);

        // FETCH timeout: 15 unready cycles then FAULT.
        Opcode = OpSw;
        for (int k = 0; k < 15; k++) checkCycle(4'd0, 1'b0, 1'b0, "fetch_wait");
        checkCycle(4'd15, 1'b1, 1'b0, "fetch_timeout");
        doReset();

        // sw timeout at the limit, then MemReady on the 15th cycle wins.
        Opcode = OpSw;
        checkCycle(4'd0, 1'b1, 1'b0, "sw_to");
        checkCycle(4'd1, 1'b0, 1'b0, "sw_to");
        checkCycle(4'd2, 1'b0, 1'b0, "sw_to");
        for (int k = 0; k < 15; k++) checkCycle(4'd5, 1'b0, 1'b0, "sw_wait");
        checkCycle(4'd15, 1'b0, 1'b0, "sw_timeout");
        doReset();
        Opcode = OpSw;
        checkCycle(4'd0, 1'b1, 1'b0, "sw_ok");
        checkCycle(4'd1, 1'b0, 1'b0, "sw_ok");
        checkCycle(4'd2, 1'b0, 1'b0, "sw_ok");
        for (int k = 0; k < 14; k++) checkCycle(4'd5, 1'b0, 1'b0, "sw_ok_wait");
        checkCycle(4'd5, 1'b1, 1'b0, "sw_ok_last");
        checkCycle(4'd0, 1'b0, 1'b0, "sw_ok_fetch");

        // Random instruction stream against the phase model.
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                op = badOps[$urandom_range(0, 3)];
                runInstr(op, 1'b0, 0, 0, $urandom_range(1, 4));
                doReset();
            end else begin
                op = legalOps[$urandom_range(0, 6)];
                runInstr(op, 1'($urandom),
                         ($urandom_range(0, 7) == 0) ? 14 : $urandom_range(0, 3),
                         ($urandom_range(0, 7) == 0) ? 14 : $urandom_range(0, 3), 0);
            end
        end

        // Three instructions, then asynchronous reset mid-MEM_WR.
        doReset();
        runInstr(OpR, 1'b0, 1, 0, 0);
        runInstr(OpBeq, 1'b1, 0, 0, 0);
        runInstr(OpSw, 1'b0, 2, 1, 0);
`ifdef MULTICYCLE_CTRL_PERF_EN
        check("retire_count", RetireCount, 32'(retired));
        check("cycle_count", CycleCount, 32'(cycles));
`endif
        Opcode = OpSw;
        checkCycle(4'd0, 1'b1, 1'b0, "pre_async");
        checkCycle(4'd1, 1'b0, 1'b0, "pre_async");
        checkCycle(4'd2, 1'b0, 1'b0, "pre_async");
        checkCycle(4'd5, 1'b0, 1'b0, "pre_async_wr");
        checkCycle(4'd5, 1'b0, 1'b0, "pre_async_wr");
        MemReady = 1'b0;
        #2;
        Reset = 1'b1;
        #1;
        check("async_rst_memwrite", 32'(MemWrite), 32'd0);
        check("async_rst_state", 32'(State), 32'd0);
        check("async_rst_outputs", 32'(actual), 32'(expOut(4'd0, 1'b0, 1'b0, 6'd0)));
`ifdef MULTICYCLE_CTRL_PERF_EN
        check("async_rst_retire", RetireCount, 32'd0);
        check("async_rst_cycles", CycleCount, 32'd0);
`endif
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        checkCycle(4'd0, 1'b1, 1'b0, "post_async_fetch");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
